// File: rtl/unified_memory_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch (I) and load/store (D).
// D wins conflicts; define ARB_STARVE_GUARD_EN to force an I grant after STARVE_LIMIT lost conflicts.
module unified_memory_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [31:0]           i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [3:0]            d_be,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  mem_enable,
    output logic                  mem_write_enable,
    output logic [3:0]            mem_byte_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    owner_t rsp_owner;
    logic   conflict;
    logic   force_i;

    assign conflict = i_req && d_req;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    assign force_i = conflict && (starve_cnt == CW'(STARVE_LIMIT));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (i_gnt)
            starve_cnt <= '0;
        else if (conflict && d_gnt && (starve_cnt != CW'(STARVE_LIMIT)))
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign force_i = 1'b0;
`endif

    // Grants are masked by reset so every output is quiet while reset is held.
    assign d_gnt = reset && d_req && !force_i;
    assign i_gnt = reset && i_req && !(d_req && !force_i);

    always_comb begin
        mem_enable       = 1'b0;
        mem_write_enable = 1'b0;
        mem_byte_enable  = 4'b0000;
        mem_address      = '0;
        mem_write_data   = '0;
        if (d_gnt) begin
            mem_enable       = 1'b1;
            mem_write_enable = d_we;
            mem_byte_enable  = d_be;
            mem_address      = d_addr;
            mem_write_data   = d_wdata;
        end else if (i_gnt) begin
            mem_enable       = 1'b1;
            mem_byte_enable  = 4'b1111;
            mem_address      = i_addr;
        end
    end

    // Stores get no response; only reads claim the next-cycle data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rsp_owner <= OWN_NONE;
        else if (i_gnt)
            rsp_owner <= OWN_I;
        else if (d_gnt && !d_we)
            rsp_owner <= OWN_D;
        else
            rsp_owner <= OWN_NONE;
    end

    assign i_rvalid = (rsp_owner == OWN_I);
    assign d_rvalid = (rsp_owner == OWN_D);
    assign i_rdata  = i_rvalid ? mem_read_data : 32'h0;
    assign d_rdata  = d_rvalid ? mem_read_data : 32'h0;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Bench for unified_memory_arbiter: directed scenarios plus random traffic against a reference model.
// Honours ARB_STARVE_GUARD_EN the same way the design does.
module tb_unified_memory_arbiter;
    localparam int AW    = 12;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [3:0]    d_be;
    logic [31:0]   d_wdata;
    logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0]   i_rdata, d_rdata;
    logic          mem_enable, mem_write_enable;
    logic [3:0]    mem_byte_enable;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic [31:0]   mem_read_data = 32'h0;

    int vectors = 0;
    int errors  = 0;

    unified_memory_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int idx);
        return 32'h9E37_79B9 * (idx + 1);
    endfunction

    // Memory attached to the DUT, 1-cycle read latency, unwritten words hold init_word.
    logic [31:0] mem [int];
    always @(posedge clk) begin
        logic [31:0] w;
        int idx;
        if (mem_enable) begin
            idx = int'(mem_address[AW-1:2]);
            w = mem.exists(idx) ? mem[idx] : init_word(idx);
            if (mem_write_enable) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byte_enable[b]) w[8*b +: 8] = mem_write_data[8*b +: 8];
                mem[idx] = w;
            end else begin
                mem_read_data <= w;
            end
        end
    end

    // Reference memory maintained by the model only.
    logic [31:0] ref_mem [int];
    function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
        int idx = int'(a[AW-1:2]);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
    endfunction

    task automatic idle_inputs();
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        next_cycle();
        reset = 1;
    endtask

    task automatic test_reset();
        logic [125:0] outs;
        reset = 0;
        for (int c = 0; c < 5; c++) begin
            i_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
            d_be = 4'($urandom); i_addr = AW'($urandom); d_addr = AW'($urandom); d_wdata = $urandom;
            @(negedge clk);
            outs = {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_enable,
                    mem_write_enable, mem_byte_enable, mem_address, mem_write_data};
            vectors++;
            if (outs !== '0) begin
                errors++; $display("FAIL reset_outputs cycle %0d: got %h want 0", c, outs);
            end
            next_cycle();
        end
        idle_inputs();
        reset = 1; i_req = 1; i_addr = 12'h0A4;
        @(negedge clk);
        vectors++;
        if ({i_gnt, d_gnt, mem_enable} !== 3'b101) begin
            errors++; $display("FAIL reset_first_grant: got {i_gnt,d_gnt,en}=%b want 101", {i_gnt, d_gnt, mem_enable});
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_fetch();
        // Place 0x13 at 0x010 through the D port, then fetch it.
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 12'h010; d_wdata = 32'h0000_0013;
        ref_mem[4] = 32'h0000_0013;
        next_cycle();
        idle_inputs();
        i_req = 1; i_addr = 12'h010;
        @(negedge clk);
        vectors++;
        if ({i_gnt, d_gnt, mem_enable, mem_write_enable, mem_byte_enable, mem_address} !== {4'b1010, 4'hF, 12'h010}) begin
            errors++; $display("FAIL fetch_grant: got gnt=%b en=%b we=%b be=%h addr=%h", i_gnt, mem_enable, mem_write_enable, mem_byte_enable, mem_address);
        end
        next_cycle();
        i_req = 0;
        @(negedge clk);
        vectors++;
        if ({i_rvalid, i_rdata, d_rvalid} !== {1'b1, 32'h0000_0013, 1'b0}) begin
            errors++; $display("FAIL fetch_data: got rvalid=%b rdata=%h want 1 00000013", i_rvalid, i_rdata);
        end
        next_cycle();
    endtask

    task automatic test_conflict();
        logic [31:0] exp_ld = ref_rd(12'h100);
        i_req = 1; i_addr = 12'h020;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 12'h100;
        @(negedge clk);
        vectors++;
        if ({d_gnt, i_gnt, mem_address} !== {2'b10, 12'h100}) begin
            errors++; $display("FAIL conflict_c0: got d_gnt=%b i_gnt=%b addr=%h want 1 0 100", d_gnt, i_gnt, mem_address);
        end
        next_cycle();
        d_req = 0;
        @(negedge clk);
        vectors++;
        if ({i_gnt, d_rvalid, d_rdata, mem_address} !== {2'b11, exp_ld, 12'h020}) begin
            errors++; $display("FAIL conflict_c1: got i_gnt=%b d_rvalid=%b d_rdata=%h want 1 1 %h", i_gnt, d_rvalid, d_rdata, exp_ld);
        end
        next_cycle();
        i_req = 0;
        @(negedge clk);
        vectors++;
        if ({i_rvalid, d_rvalid, i_rdata} !== {2'b10, ref_rd(12'h020)}) begin
            errors++; $display("FAIL conflict_c2: got i_rvalid=%b d_rvalid=%b i_rdata=%h", i_rvalid, d_rvalid, i_rdata);
        end
        next_cycle();
    endtask

    task automatic test_store();
        logic [31:0] w = ref_rd(12'h104);
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 12'h104; d_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        vectors++;
        if ({d_gnt, mem_enable, mem_write_enable, mem_byte_enable, mem_address, mem_write_data} !==
            {3'b111, 4'b0011, 12'h104, 32'hAABB_CCDD}) begin
            errors++; $display("FAIL store_drive: got gnt=%b en=%b we=%b be=%b addr=%h wd=%h", d_gnt, mem_enable, mem_write_enable, mem_byte_enable, mem_address, mem_write_data);
        end
        w[15:0] = 16'hCCDD;
        ref_mem[65] = w;
        next_cycle();
        d_we = 0;
        @(negedge clk);
        vectors++;
        if (d_rvalid !== 1'b0) begin
            errors++; $display("FAIL store_no_rvalid: got d_rvalid=%b want 0", d_rvalid);
        end
        next_cycle();
        d_req = 0;
        @(negedge clk);
        vectors++;
        if ({d_rvalid, d_rdata} !== {1'b1, w}) begin
            errors++; $display("FAIL store_readback: got %b %h want 1 %h", d_rvalid, d_rdata, w);
        end
        next_cycle();
    endtask

    task automatic test_starve();
        logic [5:0] got, want;
`ifdef ARB_STARVE_GUARD_EN
        want = 6'b101111;  // bit n = D won cycle n
`else
        want = 6'b111111;
`endif
        do_reset();
        i_req = 1; i_addr = 12'h040; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 12'h200;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            got[c] = d_gnt;
            vectors++;
            if ((d_gnt ^ i_gnt) !== 1'b1) begin
                errors++; $display("FAIL starve_onehot cycle %0d: got d_gnt=%b i_gnt=%b", c, d_gnt, i_gnt);
            end
            next_cycle();
        end
        vectors++;
        if (got !== want) begin
            errors++; $display("FAIL starve_pattern: got %b want %b", got, want);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        i_req = 1; i_addr = 12'h0C0;
        next_cycle();
        i_req = 0; reset = 0;
        @(negedge clk);
        vectors++;
        if ({i_rvalid, i_rdata} !== 33'h0) begin
            errors++; $display("FAIL midflight_during: got rvalid=%b rdata=%h want 0", i_rvalid, i_rdata);
        end
        next_cycle();
        reset = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({i_rvalid, d_rvalid} !== 2'b00) begin
                errors++; $display("FAIL midflight_after cycle %0d: got i_rvalid=%b d_rvalid=%b want 00", c, i_rvalid, d_rvalid);
            end
            next_cycle();
        end
    endtask

    task automatic test_random(input int n);
        int          starve = 0;
        int          owner = 0;     // 0 none, 1 I, 2 D: who gets data this cycle
        logic [31:0] data = 0;
        int          nowner;
        logic [31:0] ndata;
        logic        conflict, ei, ed;
        logic [49:0] exp_mem, got_mem;
        do_reset();
        i_req = ($urandom_range(0, 9) < 6); i_addr = AW'($urandom);
        d_req = ($urandom_range(0, 9) < 6); d_we = 1'($urandom); d_be = 4'($urandom);
        d_addr = AW'($urandom); d_wdata = $urandom;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            conflict = i_req && d_req;
`ifdef ARB_STARVE_GUARD_EN
            ed = d_req && !(conflict && starve == LIMIT);
`else
            ed = d_req;
`endif
            ei = i_req && !ed;
            if (ed)      exp_mem = {1'b1, d_we, d_be, d_addr, d_wdata};
            else if (ei) exp_mem = {2'b10, 4'hF, i_addr, 32'h0};
            else         exp_mem = '0;
            got_mem = {mem_enable, mem_write_enable, mem_byte_enable, mem_address, mem_write_data};
            vectors++;
            if ({i_gnt, d_gnt} !== {ei, ed}) begin
                errors++; $display("FAIL rand_grant cycle %0d: got i=%b d=%b want i=%b d=%b", c, i_gnt, d_gnt, ei, ed);
            end
            vectors++;
            if (got_mem !== exp_mem) begin
                errors++; $display("FAIL rand_mem cycle %0d: got %h want %h", c, got_mem, exp_mem);
            end
            vectors++;
            if ({i_rvalid, i_rdata, d_rvalid, d_rdata} !==
                {owner == 1, (owner == 1) ? data : 32'h0, owner == 2, (owner == 2) ? data : 32'h0}) begin
                errors++; $display("FAIL rand_rsp cycle %0d: got i=%b/%h d=%b/%h want owner %0d data %h", c, i_rvalid, i_rdata, d_rvalid, d_rdata, owner, data);
            end
            nowner = 0; ndata = 0;
            if (ei) begin
                nowner = 1; ndata = ref_rd(i_addr);
            end else if (ed && !d_we) begin
                nowner = 2; ndata = ref_rd(d_addr);
            end else if (ed) begin
                ndata = ref_rd(d_addr);
                for (int b = 0; b < 4; b++)
                    if (d_be[b]) ndata[8*b +: 8] = d_wdata[8*b +: 8];
                ref_mem[int'(d_addr[AW-1:2])] = ndata;
                ndata = 0;
            end
            if (ei) starve = 0;
            else if (conflict && ed && starve < LIMIT) starve++;
            next_cycle();
            owner = nowner; data = ndata;
            if (!i_req || ei) begin
                i_req = ($urandom_range(0, 9) < 6); i_addr = AW'($urandom);
            end
            if (!d_req || ed) begin
                d_req = ($urandom_range(0, 9) < 6); d_we = 1'($urandom); d_be = 4'($urandom);
                d_addr = AW'($urandom); d_wdata = $urandom;
            end
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        next_cycle();
        test_reset();
        test_fetch();
        test_conflict();
        test_store();
        test_starve();
        test_reset_midflight();
        test_random(400);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
